// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: frame FSM states, prefix codes and entry layout.
package ps2_pkg;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} ps2_state_e;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam int unsigned ENT_EXT = 9;
    localparam int unsigned ENT_BRK = 8;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a level filter: the output follows the synced input only
// after FILT_LEN consecutive samples disagree with the current output.
module ps2_sync_filter #(
    parameter int unsigned FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(FILT_LEN);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: filtered pin sampling, frame checking, optional F0/E0 prefix folding
// and a show-ahead FIFO with valid/ready output.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DECODE      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     kclk,
    input  logic                     kdata,
    output logic [9:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_parity,
    output logic                     err_frame,
    output logic                     err_timeout,
    output logic                     err_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic kclk_f, kdata_f, kclk_prev_q, fall;

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_kclk (
        .clk  (clk),
        .rst  (rst),
        .din  (kclk),
        .dout (kclk_f)
    );

    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_filt_kdata (
        .clk  (clk),
        .rst  (rst),
        .din  (kdata),
        .dout (kdata_f)
    );

    assign fall = kclk_prev_q & ~kclk_f;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          brk_p_q, brk_p_d, ext_p_q, ext_p_d;
    logic          push_q, push_d;
    logic [9:0]    push_data_q, push_data_d;
    logic          err_par_q, err_par_d, err_frm_q, err_frm_d, err_tmo_q, err_tmo_d;
    logic          timeout;

    assign timeout = (state_q != StIdle) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else if (fall) begin
            unique case (state_q)
                StIdle:   if (!kdata_f) state_d = StData;
                StData:   if (bitcnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        brk_p_d     = brk_p_q;
        ext_p_d     = ext_p_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        err_par_d   = 1'b0;
        err_frm_d   = 1'b0;
        err_tmo_d   = 1'b0;
        tmo_d       = (fall || state_q == StIdle || timeout) ? '0 : tmo_q + TW'(1);
        if (timeout) begin
            err_tmo_d = 1'b1;
            brk_p_d   = 1'b0;
            ext_p_d   = 1'b0;
        end else if (fall) begin
            unique case (state_q)
                StIdle:   bitcnt_d = '0;
                StData: begin
                    shift_d  = {kdata_f, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                StParity: parity_d = kdata_f;
                StStop: begin
                    if (!odd_parity_ok(shift_q, parity_q)) begin
                        err_par_d = 1'b1;
                        brk_p_d   = 1'b0;
                        ext_p_d   = 1'b0;
                    end else if (!kdata_f) begin
                        err_frm_d = 1'b1;
                        brk_p_d   = 1'b0;
                        ext_p_d   = 1'b0;
                    end else if (DECODE != 0 && shift_q == PS2_BREAK) begin
                        brk_p_d = 1'b1;
                    end else if (DECODE != 0 && shift_q == PS2_EXT) begin
                        ext_p_d = 1'b1;
                    end else begin
                        // Pending flags stay 0 when DECODE=0, so raw bytes carry no flags.
                        push_d               = 1'b1;
                        push_data_d[7:0]     = shift_q;
                        push_data_d[ENT_EXT] = ext_p_q;
                        push_data_d[ENT_BRK] = brk_p_q;
                        brk_p_d              = 1'b0;
                        ext_p_d              = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO: register array with wrapping pointers; last_q keeps out_data stable while empty.
    logic [9:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic [9:0]  last_q, last_d;
    logic        full, pop, wr_en, ovf_q, ovf_d;

    always_comb begin
        full     = (count_q == (AW + 1)'(DEPTH));
        pop      = out_valid & out_ready;
        wr_en    = push_q & (!full | pop);
        ovf_d    = push_q & full & !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
        last_d   = pop ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_prev_q <= 1'b1;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            brk_p_q     <= 1'b0;
            ext_p_q     <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            err_par_q   <= 1'b0;
            err_frm_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_q      <= '0;
        end else begin
            kclk_prev_q <= kclk_f;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            brk_p_q     <= brk_p_d;
            ext_p_q     <= ext_p_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            err_par_q   <= err_par_d;
            err_frm_q   <= err_frm_d;
            err_tmo_q   <= err_tmo_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_q      <= last_d;
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_data     = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign fifo_count   = count_q;
    assign err_parity   = err_par_q;
    assign err_frame    = err_frm_q;
    assign err_timeout  = err_tmo_q;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: stimulus queues expected beats and posted checks,
// a negedge monitor compares them against the DUT.
module tb_ps2_rx_fifo;

    localparam int unsigned FL  = 4;
    localparam int unsigned TMO = 400;
    localparam int unsigned DEP = 16;
    localparam int          H   = 10;

    logic       clk = 1'b0;
    logic       rst, kclk, kdata, out_ready;
    logic [9:0] out_data;
    logic       out_valid;
    logic [4:0] fifo_count;
    logic       err_parity, err_frame, err_timeout, err_overflow;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FILT_LEN    (FL),
        .TIMEOUT_CYC (TMO),
        .DEPTH       (DEP),
        .DECODE      (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kclk         (kclk),
        .kdata        (kdata),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .err_parity   (err_parity),
        .err_frame    (err_frame),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic [9:0] exp_q[$];
    chk_t       chk_q[$];
    int n_checks = 0, n_fail = 0;
    int cnt_par = 0, cnt_frm = 0, cnt_tmo = 0, cnt_ovf = 0, max_cnt = 0;

    always @(negedge clk) begin
        chk_t       c;
        logic [9:0] e;
        if (!rst) begin
            cnt_par += int'(err_parity);
            cnt_frm += int'(err_frame);
            cnt_tmo += int'(err_timeout);
            cnt_ovf += int'(err_overflow);
            if (out_ready && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected got=%h exp=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL sb_beat got=%h exp=%h", out_data, e);
                    end
                end
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_fail++;
                $display("FAIL %s got=%0h exp=%0h", c.name, c.act, c.exp);
            end
        end
    end

    task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = nm;
        c.act  = a;
        c.exp  = e;
        chk_q.push_back(c);
    endtask

    function automatic int errs();
        return cnt_par + cnt_frm + cnt_tmo + cnt_ovf;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        kdata = b;
        wait_cyc(H);
        kclk = 1'b0;
        wait_cyc(H);
        kclk = 1'b1;
    endtask

    task automatic glitch();
        kclk = 1'b0;
        wait_cyc(FL - 1);
        kclk = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input int glitch_at);
        logic p;
        p = ~(^d) ^ par_flip;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_at) glitch();
            send_bit(d[i]);
        end
        send_bit(p);
        send_bit(stop);
        kdata = 1'b1;
        wait_cyc(12);
    endtask

    initial begin
        int e0, p0, f0, t0, o0;
        rst = 1'b1; kclk = 1'b1; kdata = 1'b1; out_ready = 1'b0;
        wait_cyc(5);
        post("rst_valid", 32'(out_valid), 0);
        post("rst_data", 32'(out_data), 0);
        post("rst_count", 32'(fifo_count), 0);
        post("rst_errs", 32'({err_parity, err_frame, err_timeout, err_overflow}), 0);
        rst = 1'b0;
        wait_cyc(3);

        // Single make code
        out_ready = 1'b1;
        e0 = errs();
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        post("t1_no_err", 32'(errs() - e0), 0);
        post("t1_sb_empty", 32'(exp_q.size()), 0);

        // Break and extended-break prefixes fold into flags
        exp_q.push_back(10'h11C);
        exp_q.push_back(10'h375);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_frame(8'h75, 1'b0, 1'b1, -1);
        post("t2_max_count", 32'(max_cnt), 1);
        post("t2_no_err", 32'(errs() - e0), 0);
        post("t2_sb_empty", 32'(exp_q.size()), 0);

        // Parity, frame and combined errors
        p0 = cnt_par; f0 = cnt_frm;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        post("t3_par_pulse", 32'(cnt_par - p0), 1);
        post("t3_par_no_frm", 32'(cnt_frm - f0), 0);
        post("t3_count", 32'(fifo_count), 0);
        exp_q.push_back(10'h032);
        send_frame(8'h32, 1'b0, 1'b1, -1);
        send_frame(8'h21, 1'b0, 1'b0, -1);
        post("t3_frm_pulse", 32'(cnt_frm - f0), 1);
        send_frame(8'h21, 1'b1, 1'b0, -1);
        post("t3_both_par", 32'(cnt_par - p0), 2);
        post("t3_both_frm", 32'(cnt_frm - f0), 1);
        // An error between prefix and code must clear the pending break flag
        exp_q.push_back(10'h01C);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_frame(8'h21, 1'b0, 1'b0, -1);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        post("t3_sb_empty", 32'(exp_q.size()), 0);

        // Timeout after partial frame, pending break flag cleared
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        t0 = cnt_tmo;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        kdata = 1'b1;
        wait_cyc(TMO + 20);
        post("t4_tmo_pulse", 32'(cnt_tmo - t0), 1);
        post("t4_idle", 32'(dut.state_q), 0);
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        post("t4_sb_empty", 32'(exp_q.size()), 0);

        // Overflow with consumer stalled, then drain in order
        out_ready = 1'b0;
        o0 = cnt_ovf;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) exp_q.push_back(10'(i));
            send_frame(8'(i), 1'b0, 1'b1, -1);
        end
        post("t5_full_count", 32'(fifo_count), 16);
        post("t5_ovf_pulse", 32'(cnt_ovf - o0), 1);
        post("t5_head", 32'(out_data), 32'h001);
        out_ready = 1'b1;
        wait_cyc(30);
        post("t5_sb_empty", 32'(exp_q.size()), 0);
        post("t5_drained", 32'(fifo_count), 0);
        post("t5_hold_data", 32'(out_data), 32'h010);

        // Sub-threshold kclk glitches in IDLE and DATA
        e0 = errs();
        glitch();
        wait_cyc(10);
        post("t6_idle_glitch", 32'(dut.state_q), 0);
        exp_q.push_back(10'h05A);
        send_frame(8'h5A, 1'b0, 1'b1, 3);
        post("t6_no_err", 32'(errs() - e0), 0);
        post("t6_sb_empty", 32'(exp_q.size()), 0);

        // Reset mid-frame with a held entry
        out_ready = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        post("t7_pre_count", 32'(fifo_count), 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        kdata = 1'b1;
        wait_cyc(3);
        post("t7_valid", 32'(out_valid), 0);
        post("t7_count", 32'(fifo_count), 0);
        post("t7_data", 32'(out_data), 0);
        post("t7_idle", 32'(dut.state_q), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        e0 = errs();
        wait_cyc(TMO + 100);
        post("t7_no_err", 32'(errs() - e0), 0);
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        post("t7_sb_empty", 32'(exp_q.size()), 0);

        wait_cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
